collision_sched: RTL and testbench

- Per-frame scheduler that shares one combinational collision checker across up to N_GHOSTS enemies.
- On each frame tick it snapshots Yoshi and ghost positions, then presents one ghost per cycle to the shared checker and collects the results.
- It resolves at most one hit per frame, and owns the lives counter, the post-hit invulnerability window and the sticky game-over flag.
- Sits between the position controllers (Yoshi/ghost movers) and the game-state/draw logic.

---
 rtl/collision_sched.sv | 198 +++++++++++++++++++
 tb/tb_collision_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_sched.sv
// Per-frame collision scheduler: time-shares one checker across ghost slots, owns lives/invuln/game_over.
// Optional hit counter output enabled by COLLISION_SCHED_HIT_COUNT_EN.
module collision_sched #(
  parameter int unsigned N_GHOSTS      = 8,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter logic [9:0]  PARK_X        = 10'd1000,
  parameter logic [9:0]  PARK_Y        = 10'd1000
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     restart,
  input  logic                     direction,
  input  logic [9:0]               y_x,
  input  logic [9:0]               y_y,
  input  logic [10*N_GHOSTS-1:0]   ghost_x_bus,
  input  logic [10*N_GHOSTS-1:0]   ghost_y_bus,
  input  logic [N_GHOSTS-1:0]      ghost_en,
  output logic                     chk_dir,
  output logic [9:0]               chk_y_x,
  output logic [9:0]               chk_y_y,
  output logic [9:0]               chk_g_x,
  output logic [9:0]               chk_g_y,
  input  logic                     chk_hit,
  output logic                     busy,
  output logic                     hit,
  output logic [3:0]               hit_idx,
  output logic [2:0]               lives,
  output logic                     invuln,
  output logic                     game_over,
`ifdef COLLISION_SCHED_HIT_COUNT_EN
  output logic [7:0]               hit_count,
`endif
  output logic                     frame_overrun
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = CW * N_GHOSTS;

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

  state_t                state_q;
  logic [3:0]            slot_q;
  logic                  found_q;
  logic [3:0]            found_idx_q;
  logic [GW-1:0]         gx_snap_q, gy_snap_q;
  logic [N_GHOSTS-1:0]   en_snap_q;
  logic [7:0]            invuln_cnt_q;
  logic                  chk_dir_q;
  logic [9:0]            chk_y_x_q, chk_y_y_q, chk_g_x_q, chk_g_y_q;
  logic                  busy_q, hit_q, invuln_q, game_over_q, frame_overrun_q;
  logic [3:0]            hit_idx_q;
  logic [2:0]            lives_q;
`ifdef COLLISION_SCHED_HIT_COUNT_EN
  logic [7:0]            hit_count_q;
`endif

  logic [4:0]            slot_nxt_c;
  logic [9:0]            nxt_gx_c, nxt_gy_c;
  logic                  en_cur_c;
  logic                  accept_c;

  // Next slot to present, and the enable of the slot currently being judged.
  always_comb begin
    slot_nxt_c = 5'(slot_q) + 5'd1;
    nxt_gx_c   = PARK_X;
    nxt_gy_c   = PARK_Y;
    en_cur_c   = 1'b0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      if (5'(i) == slot_nxt_c && en_snap_q[i]) begin
        nxt_gx_c = gx_snap_q[CW*i +: CW];
        nxt_gy_c = gy_snap_q[CW*i +: CW];
      end
      if (4'(i) == slot_q) en_cur_c = en_snap_q[i];
    end
    accept_c = found_q && (invuln_cnt_q == 8'd0) && !game_over_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q         <= IDLE;
      slot_q          <= 4'd0;
      found_q         <= 1'b0;
      found_idx_q     <= 4'd0;
      gx_snap_q       <= '0;
      gy_snap_q       <= '0;
      en_snap_q       <= '0;
      invuln_cnt_q    <= 8'd0;
      chk_dir_q       <= 1'b0;
      chk_y_x_q       <= 10'd0;
      chk_y_y_q       <= 10'd0;
      chk_g_x_q       <= PARK_X;
      chk_g_y_q       <= PARK_Y;
      busy_q          <= 1'b0;
      hit_q           <= 1'b0;
      hit_idx_q       <= 4'd0;
      lives_q         <= 3'(LIVES_INIT);
      invuln_q        <= 1'b0;
      game_over_q     <= 1'b0;
      frame_overrun_q <= 1'b0;
`ifdef COLLISION_SCHED_HIT_COUNT_EN
      hit_count_q     <= 8'd0;
`endif
    end else begin
      hit_q           <= 1'b0;
      frame_overrun_q <= 1'b0;
      if (restart) begin
        // New game abandons any scan in flight.
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        found_q      <= 1'b0;
        lives_q      <= 3'(LIVES_INIT);
        game_over_q  <= 1'b0;
        invuln_cnt_q <= 8'd0;
        invuln_q     <= 1'b0;
        chk_g_x_q    <= PARK_X;
        chk_g_y_q    <= PARK_Y;
`ifdef COLLISION_SCHED_HIT_COUNT_EN
        hit_count_q  <= 8'd0;
`endif
      end else begin
        if (frame_tick && busy_q) frame_overrun_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (frame_tick) begin
              gx_snap_q <= ghost_x_bus;
              gy_snap_q <= ghost_y_bus;
              en_snap_q <= ghost_en;
              chk_dir_q <= direction;
              chk_y_x_q <= y_x;
              chk_y_y_q <= y_y;
              chk_g_x_q <= ghost_en[0] ? ghost_x_bus[CW-1:0] : PARK_X;
              chk_g_y_q <= ghost_en[0] ? ghost_y_bus[CW-1:0] : PARK_Y;
              if (invuln_cnt_q != 8'd0) begin
                invuln_cnt_q <= invuln_cnt_q - 8'd1;
                invuln_q     <= (invuln_cnt_q > 8'd1);
              end
              slot_q  <= 4'd0;
              found_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= SCAN;
            end
          end
          SCAN: begin
            // Lowest qualified slot wins; later hits never overwrite it.
            if (chk_hit && en_cur_c && !found_q) begin
              found_q     <= 1'b1;
              found_idx_q <= slot_q;
            end
            if (slot_q == 4'(N_GHOSTS - 1)) begin
              state_q <= RESOLVE;
            end else begin
              slot_q    <= slot_q + 4'd1;
              chk_g_x_q <= nxt_gx_c;
              chk_g_y_q <= nxt_gy_c;
            end
          end
          RESOLVE: begin
            if (accept_c) begin
              hit_q        <= 1'b1;
              hit_idx_q    <= found_idx_q;
              invuln_cnt_q <= 8'(INVULN_FRAMES);
              invuln_q     <= 1'b1;
              if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
              game_over_q  <= (lives_q <= 3'd1);
            end
`ifdef COLLISION_SCHED_HIT_COUNT_EN
            if (found_q && hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
`endif
            busy_q    <= 1'b0;
            chk_g_x_q <= PARK_X;
            chk_g_y_q <= PARK_Y;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign chk_dir       = chk_dir_q;
  assign chk_y_x       = chk_y_x_q;
  assign chk_y_y       = chk_y_y_q;
  assign chk_g_x       = chk_g_x_q;
  assign chk_g_y       = chk_g_y_q;
  assign busy          = busy_q;
  assign hit           = hit_q;
  assign hit_idx       = hit_idx_q;
  assign lives         = lives_q;
  assign invuln        = invuln_q;
  assign game_over     = game_over_q;
  assign frame_overrun = frame_overrun_q;
`ifdef COLLISION_SCHED_HIT_COUNT_EN
  assign hit_count     = hit_count_q;
`endif

endmodule

// File: tb/tb_collision_sched.sv
// Bench for collision_sched: frame-level behavioural model plus directed literal checks.
module tb_collision_sched;
  localparam int N  = 8;
  localparam int LI = 3;
  localparam int IF = 4;

  logic pclk = 1'b0;
  logic rst = 1'b1, frame_tick = 1'b0, restart = 1'b0, direction = 1'b0;
  logic [9:0] y_x = 10'd0, y_y = 10'd0;
  logic [10*N-1:0] ghost_x_bus = '0, ghost_y_bus = '0;
  logic [N-1:0] ghost_en = '0;
  logic chk_dir, chk_hit, busy, hit, invuln, game_over, frame_overrun;
  logic [9:0] chk_y_x, chk_y_y, chk_g_x, chk_g_y;
  logic [3:0] hit_idx;
  logic [2:0] lives;
`ifdef COLLISION_SCHED_HIT_COUNT_EN
  logic [7:0] hit_count;
`endif

  int checks = 0, errors = 0, cyc = 0;

  collision_sched #(.N_GHOSTS(N), .LIVES_INIT(LI), .INVULN_FRAMES(IF),
                    .PARK_X(10'd1000), .PARK_Y(10'd1000)) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .direction(direction), .y_x(y_x), .y_y(y_y),
    .ghost_x_bus(ghost_x_bus), .ghost_y_bus(ghost_y_bus), .ghost_en(ghost_en),
    .chk_dir(chk_dir), .chk_y_x(chk_y_x), .chk_y_y(chk_y_y),
    .chk_g_x(chk_g_x), .chk_g_y(chk_g_y), .chk_hit(chk_hit),
    .busy(busy), .hit(hit), .hit_idx(hit_idx), .lives(lives), .invuln(invuln),
    .game_over(game_over),
`ifdef COLLISION_SCHED_HIT_COUNT_EN
    .hit_count(hit_count),
`endif
    .frame_overrun(frame_overrun));

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Stub checker: any ghost presented at x==100 collides.
  assign chk_hit = (chk_g_x == 10'd100);

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: t counts edges since the accepted tick, -1 when idle.
  int m_t = -1, m_lives = LI, m_cnt = 0, m_idx = 0, m_found = -1, m_hc = 0;
  bit m_go = 0, m_hit = 0, m_ovr = 0, m_dir = 0;
  int m_yx = 0, m_yy = 0;
  int m_gx[N], m_gy[N];
  bit m_en[N];

  always @(posedge pclk) begin
    m_hit = 0; m_ovr = 0;
    if (rst) begin
      m_t = -1; m_lives = LI; m_cnt = 0; m_idx = 0; m_go = 0; m_hc = 0;
      m_dir = 0; m_yx = 0; m_yy = 0;
    end else if (restart) begin
      m_t = -1; m_lives = LI; m_cnt = 0; m_go = 0; m_hc = 0;
    end else if (m_t >= 0) begin
      if (frame_tick) m_ovr = 1;
      m_t++;
      if (m_t == N + 1) begin
        if (m_found >= 0) begin
          if (m_hc < 255) m_hc++;
          if (m_cnt == 0 && !m_go) begin
            m_hit = 1; m_idx = m_found; m_cnt = IF;
            if (m_lives > 0) m_lives--;
            m_go = (m_lives == 0);
          end
        end
        m_t = -1;
      end
    end else if (frame_tick) begin
      m_dir = direction; m_yx = y_x; m_yy = y_y; m_found = -1;
      for (int i = 0; i < N; i++) begin
        m_gx[i] = ghost_x_bus[10*i +: 10];
        m_gy[i] = ghost_y_bus[10*i +: 10];
        m_en[i] = ghost_en[i];
        if (m_found < 0 && m_en[i] && m_gx[i] == 100) m_found = i;
      end
      if (m_cnt > 0) m_cnt--;
      m_t = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge pclk) begin
    if (cyc >= 1) begin
      cmp("busy", 16'(busy), 16'(m_t >= 0));
      cmp("hit", 16'(hit), 16'(m_hit));
      cmp("hit_idx", 16'(hit_idx), 16'(m_idx));
      cmp("lives", 16'(lives), 16'(m_lives));
      cmp("invuln", 16'(invuln), 16'(m_cnt != 0));
      cmp("game_over", 16'(game_over), 16'(m_go));
      cmp("frame_overrun", 16'(frame_overrun), 16'(m_ovr));
      cmp("chk_dir", 16'(chk_dir), 16'(m_dir));
      cmp("chk_y_x", 16'(chk_y_x), 16'(m_yx));
      cmp("chk_y_y", 16'(chk_y_y), 16'(m_yy));
      if (m_t < 0) begin
        cmp("chk_g_x_park", 16'(chk_g_x), 16'd1000);
        cmp("chk_g_y_park", 16'(chk_g_y), 16'd1000);
      end else if (m_t < N) begin
        cmp("chk_g_x_slot", 16'(chk_g_x), 16'(m_en[m_t] ? m_gx[m_t] : 1000));
        cmp("chk_g_y_slot", 16'(chk_g_y), 16'(m_en[m_t] ? m_gy[m_t] : 1000));
      end
`ifdef COLLISION_SCHED_HIT_COUNT_EN
      cmp("hit_count", 16'(hit_count), 16'(m_hc));
`endif
    end
  end

  task automatic set_scene(input logic [N-1:0] hit_mask, input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      ghost_x_bus[10*i +: 10] = hit_mask[i] ? 10'd100 : 10'(200 + 20*i);
      ghost_y_bus[10*i +: 10] = 10'(50 + i);
    end
    ghost_en = en;
  endtask

  task automatic do_restart();
    @(posedge pclk); #2 restart = 1'b1;
    @(posedge pclk); #2 restart = 1'b0;
  endtask

  // One frame: tick launched at step 0; optional second tick, restart or rst at step k.
  task automatic run_frame(input int tick2_at, input int rs_at, input int rst_at,
                           output int lat, output int ovr_n,
                           output logic [9:0] g2, output logic [9:0] g5, output logic b_after);
    int c0;
    lat = -1; ovr_n = 0; g2 = '0; g5 = '0; b_after = 1'b1;
    @(posedge pclk); #2; c0 = cyc; frame_tick = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge pclk); #2;
      frame_tick = (i == tick2_at);
      restart    = (i == rs_at);
      rst        = (i == rst_at);
      @(negedge pclk);
      if (hit && lat < 0) lat = cyc - c0;
      if (frame_overrun) ovr_n++;
      if (cyc - c0 == 3) g2 = chk_g_x;
      if (cyc - c0 == 6) g5 = chk_g_x;
      if (cyc - c0 == rs_at + 1 || cyc - c0 == rst_at + 1) b_after = busy;
    end
    @(posedge pclk); #2 frame_tick = 1'b0; restart = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int lat, ovr;
    logic [9:0] g2, g5;
    logic ba;
    direction = 1'b1; y_x = 10'd320; y_y = 10'd240;
    set_scene(8'h00, 8'hFF);
    repeat (3) @(posedge pclk);
    #2 rst = 1'b0;
    @(negedge pclk);
    cmp("reset_lives", 16'(lives), 16'd3);
    cmp("reset_park", 16'(chk_g_x), 16'd1000);
    cmp("reset_busy", 16'(busy), 16'd0);

    // Single ghost at slot 3.
    set_scene(8'h08, 8'hFF);
    run_frame(0, 0, 0, lat, ovr, g2, g5, ba);
    cmp("lat_slot3", 16'(lat), 16'd10);
    cmp("idx_slot3", 16'(hit_idx), 16'd3);
    cmp("lives_after_hit", 16'(lives), 16'd2);
    cmp("invuln_after_hit", 16'(invuln), 16'd1);

    // Two colliding ghosts: lowest wins; masking slot 2 promotes slot 5.
    do_restart(); set_scene(8'h24, 8'hFF);
    run_frame(0, 0, 0, lat, ovr, g2, g5, ba);
    cmp("idx_lowest", 16'(hit_idx), 16'd2);
    cmp("lives_single_dec", 16'(lives), 16'd2);
    do_restart(); set_scene(8'h24, 8'hFB);
    run_frame(0, 0, 0, lat, ovr, g2, g5, ba);
    cmp("idx_masked", 16'(hit_idx), 16'd5);
    cmp("park_slot2", 16'(g2), 16'd1000);
    cmp("slot5_x", 16'(g5), 16'd100);

    // Invulnerability window, then run down to game over.
    do_restart(); set_scene(8'h08, 8'hFF);
    for (int f = 0; f <= 12; f++) begin
      run_frame(0, 0, 0, lat, ovr, g2, g5, ba);
      if (f >= 1 && f <= 3) cmp("invuln_block", 16'(lat == -1), 16'd1);
      if (f == 3) cmp("lives_f3", 16'(lives), 16'd2);
      if (f == 4) begin
        cmp("lat_f4", 16'(lat), 16'd10);
        cmp("lives_f4", 16'(lives), 16'd1);
`ifdef COLLISION_SCHED_HIT_COUNT_EN
        cmp("hit_count_f4", 16'(hit_count), 16'd5);
`endif
      end
      if (f == 8) cmp("game_over_f8", 16'({lives, game_over}), 16'({3'd0, 1'b1}));
      if (f == 12) begin
        cmp("no_hit_gameover", 16'(lat == -1), 16'd1);
        cmp("lives_stay0", 16'(lives), 16'd0);
      end
    end
    do_restart();
    @(negedge pclk);
    cmp("restart_state", 16'({lives, game_over, invuln}), 16'({3'd3, 1'b0, 1'b0}));

    // Overrun: second tick 4 cycles later is ignored.
    set_scene(8'h08, 8'hFF);
    run_frame(4, 0, 0, lat, ovr, g2, g5, ba);
    cmp("overrun_pulses", 16'(ovr), 16'd1);
    cmp("overrun_lat", 16'(lat), 16'd10);

    // Restart at slot 4 abandons the scan.
    do_restart(); set_scene(8'h08, 8'hFF);
    run_frame(0, 5, 0, lat, ovr, g2, g5, ba);
    cmp("restart_no_hit", 16'(lat == -1), 16'd1);
    cmp("restart_busy", 16'(ba), 16'd0);

    // Reset mid-scan after a prior hit.
    run_frame(0, 0, 0, lat, ovr, g2, g5, ba);
    cmp("pre_rst_lives", 16'(lives), 16'd2);
    run_frame(0, 0, 5, lat, ovr, g2, g5, ba);
    cmp("rst_no_hit", 16'(lat == -1), 16'd1);
    cmp("rst_busy", 16'(ba), 16'd0);
    cmp("rst_outputs", 16'({lives, invuln, hit_idx, game_over}), 16'({3'd3, 1'b0, 4'd0, 1'b0}));
    cmp("rst_chk_y_x", 16'(chk_y_x), 16'd0);

    // Restart coincident with tick starts nothing.
    @(posedge pclk); #2 restart = 1'b1; frame_tick = 1'b1;
    @(posedge pclk); #2 restart = 1'b0; frame_tick = 1'b0;
    @(negedge pclk);
    cmp("restart_tick_busy", 16'(busy), 16'd0);

    repeat (4) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
